// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine host driver.
package gcd_pkg;
  typedef enum logic [2:0] {IDLE, CLR, LOAD_A, LOAD_B, WAIT, RESP} state_t;

  localparam int DEFAULT_WIDTH          = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 70000;
endpackage

// File: rtl/gcd_watchdog.sv
// Saturating cycle counter that flags the cycle in which the LIMIT-th enabled
// cycle is being spent, so the owner can leave on that same edge.
module gcd_watchdog #(
  parameter int LIMIT = 70000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] MAX_COUNT  = CW'(LIMIT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX_COUNT)) begin
      count <= count + 1'b1;
    end
  end

  // Count c means c enabled cycles already elapsed; this one is number c+1.
  assign expired = enable && (count >= LAST_COUNT);
endmodule

// File: rtl/gcd_host_driver.sv
// Host-side driver for the GCD engine: clear, serial A/B load, wait for done,
// return the result; zero operands bypass the engine, a watchdog bounds WAIT.
module gcd_host_driver
  import gcd_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_err,
  output logic             gcd_clr,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid holds its payload stable until that edge.
  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             wd_clear;
  logic             wd_enable;
  logic             wd_expired;

  assign wd_clear  = (state == LOAD_B);
  assign wd_enable = (state == WAIT);

  gcd_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_gcd   <= '0;
      rsp_err   <= 1'b0;
      gcd_clr   <= 1'b0;
      gcd_start <= 1'b0;
      gcd_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            a_q       <= req_a;
            b_q       <= req_b;
            req_ready <= 1'b0;
            // A zero operand would never terminate a subtract-based engine.
            if ((req_a == '0) || (req_b == '0)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_gcd   <= req_a | req_b;
              rsp_err   <= (req_a == '0) && (req_b == '0);
            end else begin
              state    <= CLR;
              gcd_clr  <= 1'b1;
              gcd_data <= '0;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        CLR: begin
          state     <= LOAD_A;
          gcd_clr   <= 1'b0;
          gcd_start <= 1'b1;
          gcd_data  <= a_q;
        end
        LOAD_A: begin
          state     <= LOAD_B;
          gcd_start <= 1'b0;
          gcd_data  <= b_q;
        end
        LOAD_B: begin
          state    <= WAIT;
          gcd_data <= '0;
        end
        WAIT: begin
          if (gcd_done) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_gcd   <= gcd_result;
            rsp_err   <= 1'b0;
          end else if (wd_expired) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_gcd   <= '0;
            rsp_err   <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          gcd_clr   <= 1'b0;
          gcd_start <= 1'b0;
          gcd_data  <= '0;
        end
      endcase
    end
  end
endmodule
